// File: rtl/riscv_pkg.sv
// Shared fetch/decode types: instruction size and the {addr,data} pair that the
// fetch unit hands to decode.
package riscv_pkg;

   localparam int INSN_BYTES = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } ifu_entry_t;

endpackage

// File: rtl/riscv_ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response, redirect, and the
// instruction stream towards decode.
interface riscv_ifu_if;

   logic        imem_req_vld;
   logic        imem_req_rdy;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_vld;
   logic [31:0] imem_rsp_data;
   logic        redirect_vld;
   logic [31:0] redirect_addr;
   logic        idu_stall;
   logic        ifu_vld;
   logic [31:0] ifu_addr;
   logic [31:0] ifu_data;

   modport master (
      output imem_req_vld, imem_req_addr, ifu_vld, ifu_addr, ifu_data,
      input  imem_req_rdy, imem_rsp_vld, imem_rsp_data,
             redirect_vld, redirect_addr, idu_stall
   );

   modport slave (
      input  imem_req_vld, imem_req_addr, ifu_vld, ifu_addr, ifu_data,
      output imem_req_rdy, imem_rsp_vld, imem_rsp_data,
             redirect_vld, redirect_addr, idu_stall
   );

endinterface

// File: rtl/riscv_ifu_fifo.sv
// Generic synchronous FIFO with flush; push while full is accepted only when a
// pop happens in the same cycle.
module riscv_ifu_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      // NOTE: every always_comb output gets its default first so no path can infer a latch.
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; count_q alone decides which entries are valid.
   always_ff @(posedge clock) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;

endmodule

// File: rtl/riscv_ifu.sv
// Instruction fetch unit: PC, credit-limited in-order fetch, response pairing with
// the fetch address, and redirect handling that drops stale in-flight responses.
module riscv_ifu
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input logic          clock,
   input logic          reset,
   riscv_ifu_if.master  bus
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] drop_q, drop_d;

   logic [CW-1:0] inflight, occupancy;
   logic [CW:0]   credit_sum;
   logic          aq_empty, aq_full, buf_empty, buf_full;
   logic [31:0]   aq_head;
   ifu_entry_t    buf_head, buf_wr;
   logic          accept, rsp_take, drop_hit, buf_push, buf_pop;

   // Inflight is exactly the address-queue occupancy: push on accept, pop on response.
   assign credit_sum = {1'b0, inflight} + {1'b0, occupancy};

   assign bus.imem_req_vld  = !reset && !bus.redirect_vld && !aq_full && !buf_full &&
                              (credit_sum < (CW+1)'(FIFO_DEPTH));
   assign bus.imem_req_addr = pc_q;

   assign accept   = bus.imem_req_vld && bus.imem_req_rdy;
   assign rsp_take = bus.imem_rsp_vld && !aq_empty;
   assign drop_hit = rsp_take && (drop_q != '0);
   assign buf_push = rsp_take && !drop_hit && !bus.redirect_vld;
   assign buf_pop  = !buf_empty && !bus.idu_stall;
   assign buf_wr   = '{addr: aq_head, data: bus.imem_rsp_data};

   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      if (bus.redirect_vld) begin
         // Everything still outstanding after this cycle's response is stale.
         pc_d   = bus.redirect_addr & ~32'h3;
         drop_d = inflight - CW'(rsp_take);
      end else begin
         if (accept)   pc_d   = pc_q + 32'(INSN_BYTES);
         if (drop_hit) drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q   <= RESET_ADDR;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   riscv_ifu_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_addr_q (
      .clock   (clock),
      .reset   (reset),
      .push    (accept),
      .pop     (rsp_take),
      .flush   (1'b0),
      .wr_data (pc_q),
      .rd_data (aq_head),
      .empty   (aq_empty),
      .full    (aq_full),
      .count   (inflight)
   );

   riscv_ifu_fifo #(.WIDTH($bits(ifu_entry_t)), .DEPTH(FIFO_DEPTH)) u_insn_buf (
      .clock   (clock),
      .reset   (reset),
      .push    (buf_push),
      .pop     (buf_pop),
      .flush   (bus.redirect_vld),
      .wr_data (buf_wr),
      .rd_data (buf_head),
      .empty   (buf_empty),
      .full    (buf_full),
      .count   (occupancy)
   );

   assign bus.ifu_vld  = !buf_empty;
   assign bus.ifu_addr = buf_empty ? 32'h0 : buf_head.addr;
   assign bus.ifu_data = buf_empty ? 32'h0 : buf_head.data;

endmodule
